// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a WIDTH-bit pattern out MSB-first, repeated rep times.
// Optional `SEQ_TX_GAP_EN` inserts GAP_CYCLES idle cycles between repetitions.
module seq_pattern_tx #(
    parameter int               WIDTH      = 6,
    parameter logic [WIDTH-1:0] PATTERN    = 6'b010110,
    parameter logic [3:0]       GAP_CYCLES = 4'd2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_pat_sel,
    input  logic [WIDTH-1:0] i_pat_in,
    input  logic [3:0]       i_rep,
    input  logic             i_abort,
    output logic             o_d_out,
    output logic             o_bit_valid,
    output logic             o_busy,
    output logic             o_done
);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

    localparam logic [3:0] LAST_IDX = 4'(WIDTH - 1);

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_shreg, w_shreg_nxt;
    logic [WIDTH-1:0] r_pat, w_pat_nxt;
    logic [3:0]       r_bit_idx, w_bit_idx_nxt;
    logic [3:0]       r_rep_cnt, w_rep_nxt;
    logic             r_d_out, r_bit_valid, r_busy, r_done;
    logic             w_d_out_nxt, w_bit_valid_nxt, w_busy_nxt, w_done_nxt;
    logic [WIDTH-1:0] w_sel_pat;
`ifdef SEQ_TX_GAP_EN
    logic [3:0]       r_gap_cnt, w_gap_nxt;
`else
    logic             w_unused_gap;
    assign w_unused_gap = ^GAP_CYCLES;
`endif

    assign w_sel_pat = i_pat_sel ? i_pat_in : PATTERN;

    always_comb begin
        w_state_nxt   = r_state;
        w_shreg_nxt   = r_shreg;
        w_pat_nxt     = r_pat;
        w_bit_idx_nxt = r_bit_idx;
        w_rep_nxt     = r_rep_cnt;
`ifdef SEQ_TX_GAP_EN
        w_gap_nxt     = r_gap_cnt;
`endif
        case (r_state)
            S_IDLE: begin
                if (i_start && !i_abort) begin
                    w_shreg_nxt   = w_sel_pat;
                    w_pat_nxt     = w_sel_pat;
                    w_rep_nxt     = (i_rep == 4'd0) ? 4'd1 : i_rep;
                    w_bit_idx_nxt = LAST_IDX;
                    w_state_nxt   = S_SEND;
                end
            end
            S_SEND: begin
                if (i_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_bit_idx == 4'd0) begin
                    if (r_rep_cnt > 4'd1) begin
                        w_rep_nxt     = r_rep_cnt - 4'd1;
                        w_shreg_nxt   = r_pat;
                        w_bit_idx_nxt = LAST_IDX;
`ifdef SEQ_TX_GAP_EN
                        w_gap_nxt     = GAP_CYCLES - 4'd1;
                        w_state_nxt   = S_GAP;
`endif
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end else begin
                    w_shreg_nxt   = {r_shreg[WIDTH-2:0], 1'b0};
                    w_bit_idx_nxt = r_bit_idx - 4'd1;
                end
            end
`ifdef SEQ_TX_GAP_EN
            S_GAP: begin
                if (i_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_gap_cnt == 4'd0) begin
                    w_state_nxt = S_SEND;
                end else begin
                    w_gap_nxt = r_gap_cnt - 4'd1;
                end
            end
`endif
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        w_d_out_nxt     = 1'b0;
        w_bit_valid_nxt = 1'b0;
        w_busy_nxt      = 1'b0;
        w_done_nxt      = 1'b0;
        case (w_state_nxt)
            S_SEND: begin
                w_d_out_nxt     = w_shreg_nxt[WIDTH-1];
                w_bit_valid_nxt = 1'b1;
                w_busy_nxt      = 1'b1;
            end
            S_GAP:   w_busy_nxt = 1'b1;
            S_DONE:  w_done_nxt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state     <= S_IDLE;
            r_shreg     <= '0;
            r_pat       <= '0;
            r_bit_idx   <= 4'd0;
            r_rep_cnt   <= 4'd0;
            r_d_out     <= 1'b0;
            r_bit_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef SEQ_TX_GAP_EN
            r_gap_cnt   <= 4'd0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_shreg     <= w_shreg_nxt;
            r_pat       <= w_pat_nxt;
            r_bit_idx   <= w_bit_idx_nxt;
            r_rep_cnt   <= w_rep_nxt;
            r_d_out     <= w_d_out_nxt;
            r_bit_valid <= w_bit_valid_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
`ifdef SEQ_TX_GAP_EN
            r_gap_cnt   <= w_gap_nxt;
`endif
        end
    end

    assign o_d_out     = r_d_out;
    assign o_bit_valid = r_bit_valid;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Testbench for seq_pattern_tx: directed and random transmissions checked against a frame-level model.
module tb_seq_pattern_tx;

    localparam logic [5:0] DEF_PAT = 6'b010110;
`ifdef SEQ_TX_GAP_EN
    localparam int GAP = 2;
`else
    localparam int GAP = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       pat_sel = 1'b0;
    logic [5:0] pat_in = 6'd0;
    logic [3:0] rep = 4'd0;
    logic       abort = 1'b0;
    logic       d_out, bit_valid, busy, done;

    int tests = 0;
    int fails = 0;

    seq_pattern_tx dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_pat_sel   (pat_sel),
        .i_pat_in    (pat_in),
        .i_rep       (rep),
        .i_abort     (abort),
        .o_d_out     (d_out),
        .o_bit_valid (bit_valid),
        .o_busy      (busy),
        .o_done      (done)
    );

    always #5 clk = ~clk;

    // Observed outputs packed as {d_out, bit_valid, busy, done}.
    task automatic chk(input string tag, input int idx, input logic [3:0] exp_v);
        logic [3:0] obs;
        obs = {d_out, bit_valid, busy, done};
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s[%0d] {d,vld,busy,done} observed=%b expected=%b", tag, idx, obs, exp_v);
        end
    endtask

    // Expected output stream after a start: frames of MSB-first bits, gaps between frames,
    // a done cycle, then one idle cycle. A start pulse is injected at cycle poke_at (if >= 0).
    task automatic run_tx(input string tag, input logic sel, input logic [5:0] pin,
                          input logic [3:0] rp, input int poke_at);
        logic [3:0] exp_q[$];
        logic [5:0] p;
        int         frames;
        p      = sel ? pin : DEF_PAT;
        frames = (rp == 4'd0) ? 1 : int'(rp);
        for (int f = 0; f < frames; f++) begin
            for (int b = 5; b >= 0; b--) exp_q.push_back({p[b], 3'b110});
            if (f < frames - 1)
                for (int g = 0; g < GAP; g++) exp_q.push_back(4'b0010);
        end
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0000);

        pat_sel = sel;
        pat_in  = pin;
        rep     = rp;
        start   = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        pat_in = 6'($urandom);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) @(negedge clk);
            chk(tag, i, exp_q[i]);
            if (i == poke_at) begin
                start   = 1'b1;
                pat_sel = ~sel;
                pat_in  = ~pin;
            end else begin
                start = 1'b0;
            end
        end
    endtask

    initial begin
        // Reset held with start high: nothing may launch.
        rst   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        chk("reset0", 0, 4'b0000);
        @(negedge clk);
        chk("reset1", 1, 4'b0000);
        start = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", 0, 4'b0000);

        run_tx("default_rep1", 1'b0, 6'b000000, 4'd1, -1);
        run_tx("runtime_rep3", 1'b1, 6'b111000, 4'd3, -1);
        run_tx("default_rep2", 1'b0, 6'b101010, 4'd2, -1);
        run_tx("rep0", 1'b0, 6'b000000, 4'd0, -1);
        run_tx("start_while_busy", 1'b1, 6'b110011, 4'd1, 2);

        // Abort on the third bit of the first frame.
        pat_sel = 1'b0;
        rep     = 4'd2;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("abort_pre", 0, {DEF_PAT[5], 3'b110});
        @(negedge clk);
        chk("abort_pre", 1, {DEF_PAT[4], 3'b110});
        @(negedge clk);
        chk("abort_pre", 2, {DEF_PAT[3], 3'b110});
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_post", 0, 4'b0000);
        run_tx("after_abort", 1'b1, 6'b100101, 4'd1, -1);

        // Abort and start together in IDLE: abort wins.
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("abort_start_idle", 0, 4'b0000);
        @(negedge clk);
        chk("abort_start_idle", 1, 4'b0000);

        // Reset mid-frame clears outputs on that edge.
        pat_sel = 1'b1;
        pat_in  = 6'b111111;
        rep     = 4'd3;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("rst_mid_pre", 0, 4'b1110);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("rst_mid", 0, 4'b0000);
        @(negedge clk);
        chk("rst_mid", 1, 4'b0000);

        // Random transactions, some with an ignored start mid-flight.
        for (int t = 0; t < 20; t++) begin
            run_tx("random", 1'($urandom), 6'($urandom), 4'($urandom_range(0, 5)),
                   ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 5)) : -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
